// File: rtl/oled_pkg.sv
// Shared constants, init command table and sequencer state type for the OLED frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oled_pkg;

    localparam logic [6:0]  OLED_ADDR   = 7'h3C;
    localparam int unsigned INIT_LEN    = 26;
    localparam int unsigned FRAME_BYTES = 512;
    localparam int unsigned WRAP_MAX    = 543;

    localparam logic [7:0]  CTRL_CMD    = 8'h00;
    localparam logic [7:0]  CTRL_DATA   = 8'h40;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } seq_state_t;

    // SSD1306 bring-up sequence: display off, clocking, 32-row mux,
    // charge pump on, horizontal addressing, remap, contrast, display on.
    function automatic logic [7:0] init_byte(input logic [4:0] k);
        logic [7:0] b;
        case (k)
            5'd0:  b = 8'hAE;
            5'd1:  b = 8'hD5;
            5'd2:  b = 8'h80;
            5'd3:  b = 8'hA8;
            5'd4:  b = 8'h1F;
            5'd5:  b = 8'hD3;
            5'd6:  b = 8'h00;
            5'd7:  b = 8'h40;
            5'd8:  b = 8'h8D;
            5'd9:  b = 8'h14;
            5'd10: b = 8'h20;
            5'd11: b = 8'h00;
            5'd12: b = 8'hA1;
            5'd13: b = 8'hC8;
            5'd14: b = 8'hDA;
            5'd15: b = 8'h02;
            5'd16: b = 8'h81;
            5'd17: b = 8'h8F;
            5'd18: b = 8'hD9;
            5'd19: b = 8'hF1;
            5'd20: b = 8'hDB;
            5'd21: b = 8'h40;
            5'd22: b = 8'hA4;
            5'd23: b = 8'hA6;
            5'd24: b = 8'h2E;
            5'd25: b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_frame_sequencer_if.sv
// Link between the OLED I2C master and the frame sequencer that feeds it.
// Latency: n/a (signal bundle only).
// Backpressure: none; the master paces itself through data_counter.
// Ports: master drives data_counter; slave (sequencer) drives address, r/w, control, data, continue.
interface oled_frame_sequencer_if;
    logic [9:0] data_counter;
    logic [6:0] addr_byte_out;
    logic       read_write;
    logic [7:0] control_byte_out;
    logic [7:0] data_byte_out;
    logic       continue_bit;

    modport master (
        output data_counter,
        input  addr_byte_out, read_write, control_byte_out, data_byte_out, continue_bit
    );

    modport slave (
        input  data_counter,
        output addr_byte_out, read_write, control_byte_out, data_byte_out, continue_bit
    );
endinterface

// File: rtl/oled_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// Latency: 1 clk read; a same-address write in the read clk returns the old data.
// Backpressure: none.
// Ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata (held until next re).
module oled_fb_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Read and write in the same block so a collision reads pre-write contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata      <= mem[raddr];
    end
endmodule

// File: rtl/oled_frame_sequencer.sv
// Maps the I2C master's data_counter to control/data/continue: init table first, then framebuffer stream.
// Latency: outputs update 2 clks after data_counter changes (1 clk ROM/RAM read, 1 clk output register).
// Backpressure: none; the master samples far slower than the lookup pipeline.
// Ports: clk, rst (sync, active-high), i2c (slave modport), fb_we/fb_waddr/fb_wdata write port,
//        init_done (sticky), frame_done (1-clk wrap pulse).
// Option OLED_DOUBLE_BUFFER_EN: two banks, adds fb_swap_req input and fb_swap_ack output.
module oled_frame_sequencer
    import oled_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    oled_frame_sequencer_if.slave i2c,
    input  logic                  fb_we,
    input  logic [8:0]            fb_waddr,
    input  logic [7:0]            fb_wdata,
`ifdef OLED_DOUBLE_BUFFER_EN
    input  logic                  fb_swap_req,
    output logic                  fb_swap_ack,
`endif
    output logic                  init_done,
    output logic                  frame_done
);

    logic [9:0] dc;
    logic [9:0] cnt_q;
    logic       rel_q;        // first clk after reset release forces a lookup
    logic       lookup;
    logic [9:0] j;
    logic       pad;
    logic       wrap_det;
    logic       wr_ok;
    logic       rd_en;
    seq_state_t kind;

    assign dc       = i2c.data_counter;
    assign lookup   = rel_q || (dc != cnt_q);
    assign j        = dc - 10'(INIT_LEN);
    assign pad      = (j >= 10'(FRAME_BYTES));
    assign wrap_det = (cnt_q == 10'(WRAP_MAX)) && (dc == 10'(INIT_LEN));
    assign wr_ok    = fb_we && ({1'b0, fb_waddr} < 10'(FRAME_BYTES));
    assign rd_en    = lookup && (kind == STREAM) && !pad;

    always_comb begin
        kind = HOLD;
        if (dc < 10'(INIT_LEN))
            kind = INIT;
        else if (dc <= 10'(WRAP_MAX))
            kind = STREAM;
    end

    // ---------------- framebuffer ----------------
    logic [7:0] rd_dat;

`ifdef OLED_DOUBLE_BUFFER_EN
    logic       front_q;
    logic       pending_q;
    logic       swap;
    logic       front_eff;
    logic       s1_bank;
    logic [7:0] rd0, rd1;

    // Swap decided combinationally so the fb[0] lookup on the wrap clk
    // already reads the newly published bank.
    assign swap      = wrap_det && (pending_q || fb_swap_req);
    assign front_eff = front_q ^ swap;

    oled_fb_ram u_bank0 (
        .clk  (clk),
        .we   (wr_ok && front_eff),
        .waddr(fb_waddr),
        .wdata(fb_wdata),
        .re   (rd_en && !front_eff),
        .raddr(j[8:0]),
        .rdata(rd0)
    );

    oled_fb_ram u_bank1 (
        .clk  (clk),
        .we   (wr_ok && !front_eff),
        .waddr(fb_waddr),
        .wdata(fb_wdata),
        .re   (rd_en && front_eff),
        .raddr(j[8:0]),
        .rdata(rd1)
    );

    assign rd_dat = s1_bank ? rd1 : rd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            fb_swap_ack <= 1'b0;
            s1_bank     <= 1'b0;
        end else begin
            front_q     <= front_eff;
            pending_q   <= swap ? 1'b0 : (pending_q || fb_swap_req);
            fb_swap_ack <= swap;
            if (lookup) s1_bank <= front_eff;
        end
    end
`else
    oled_fb_ram u_bank0 (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(fb_waddr),
        .wdata(fb_wdata),
        .re   (rd_en),
        .raddr(j[8:0]),
        .rdata(rd_dat)
    );
`endif

    // ---------------- stage 1: classify and read ----------------
    logic       s1_vld;
    seq_state_t s1_kind;
    logic [7:0] s1_rom;
    logic       s1_pad;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rel_q      <= 1'b1;
            s1_vld     <= 1'b0;
            s1_kind    <= INIT;
            s1_rom     <= '0;
            s1_pad     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt_q      <= dc;
            rel_q      <= 1'b0;
            s1_vld     <= lookup;
            frame_done <= wrap_det;
            if (lookup) begin
                s1_kind <= kind;
                s1_rom  <= init_byte(dc[4:0]);
                s1_pad  <= pad;
            end
        end
    end

    // ---------------- stage 2: state and output register ----------------
    seq_state_t state_q, state_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] data_q, data_d;
    logic       cont_q, cont_d;
    logic       init_d;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        cont_d  = cont_q;
        init_d  = init_done;
        if (s1_vld) begin
            state_d = s1_kind;
            case (s1_kind)
                INIT: begin
                    ctrl_d = CTRL_CMD;
                    data_d = s1_rom;
                    cont_d = 1'b0;
                end
                STREAM: begin
                    // continue_bit rises together with the data control byte
                    ctrl_d = CTRL_DATA;
                    data_d = s1_pad ? 8'h00 : rd_dat;
                    cont_d = 1'b1;
                    init_d = 1'b1;
                end
                default: begin
                    // illegal counter: drop continue so the master terminates
                    ctrl_d = CTRL_CMD;
                    data_d = 8'h00;
                    cont_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            ctrl_q    <= CTRL_CMD;
            data_q    <= init_byte(5'd0);
            cont_q    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            cont_q    <= cont_d;
            init_done <= init_d;
        end
    end

    assign i2c.addr_byte_out    = OLED_ADDR;
    assign i2c.read_write       = 1'b0;
    assign i2c.control_byte_out = ctrl_q;
    assign i2c.data_byte_out    = data_q;
    assign i2c.continue_bit     = cont_q;

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Directed bench for oled_frame_sequencer with an expected-output queue and a framebuffer model.
// Latency: checks outputs 3 clks after each data_counter step (pipeline is 2).
// Backpressure: n/a.
module tb_oled_frame_sequencer;

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] d;
        logic       k;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       fb_we;
    logic [8:0] fb_waddr;
    logic [7:0] fb_wdata;
    logic       init_done;
    logic       frame_done;
`ifdef OLED_DOUBLE_BUFFER_EN
    logic       fb_swap_req;
    logic       fb_swap_ack;
`endif

    always #5 clk = ~clk;

    oled_frame_sequencer_if bus ();

    oled_frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .i2c        (bus.slave),
        .fb_we      (fb_we),
        .fb_waddr   (fb_waddr),
        .fb_wdata   (fb_wdata),
`ifdef OLED_DOUBLE_BUFFER_EN
        .fb_swap_req(fb_swap_req),
        .fb_swap_ack(fb_swap_ack),
`endif
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    logic [7:0] init_tbl [26] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h2E, 8'hAF};

    logic [7:0] fb_m [2][512];
    int         front_idx = 0;
    exp_t       sb_q [$];
    int         errors = 0;
    int         checks = 0;
    int         fd_cnt;
    int         ack_cnt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t exp_of(input int v);
        exp_t e;
        int   jj;
        jj = v - 26;
        if (v < 26)
            e = '{c: 8'h00, d: init_tbl[v], k: 1'b0};
        else if (v <= 543)
            e = '{c: 8'h40, d: (jj < 512) ? fb_m[front_idx][jj] : 8'h00, k: 1'b1};
        else
            e = '{c: 8'h00, d: 8'h00, k: 1'b0};
        return e;
    endfunction

    task automatic model_wr(input int a, input logic [7:0] d);
`ifdef OLED_DOUBLE_BUFFER_EN
        fb_m[front_idx ^ 1][a] = d;
`else
        fb_m[front_idx][a] = d;
`endif
    endtask

    // Waits n edges, counting strobes, then pops the oldest expectation and compares.
    task automatic await_check(input string tag, input int n);
        exp_t e;
        fd_cnt  = 0;
        ack_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) fd_cnt++;
`ifdef OLED_DOUBLE_BUFFER_EN
            if (fb_swap_ack === 1'b1) ack_cnt++;
`endif
        end
        e = sb_q.pop_front();
        check({tag, ".ctrl"}, 16'(bus.control_byte_out), 16'(e.c));
        check({tag, ".data"}, 16'(bus.data_byte_out), 16'(e.d));
        check({tag, ".cont"}, 16'(bus.continue_bit), 16'(e.k));
    endtask

    task automatic step(input string tag, input int v);
        sb_q.push_back(exp_of(v));
        bus.data_counter = 10'(v);
        await_check(tag, 3);
    endtask

    task automatic fb_write(input int a, input logic [7:0] d);
        fb_we    = 1'b1;
        fb_waddr = 9'(a);
        fb_wdata = d;
        @(posedge clk); #1;
        fb_we = 1'b0;
        model_wr(a, d);
    endtask

    task automatic fill(input logic [7:0] seed);
        for (int i = 0; i < 512; i++) begin
            fb_we    = 1'b1;
            fb_waddr = 9'(i);
            fb_wdata = 8'(i) ^ seed;
            @(posedge clk); #1;
            model_wr(i, 8'(i) ^ seed);
        end
        fb_we = 1'b0;
    endtask

    // Makes back-bank writes visible: request a swap and run one wrap.
    task automatic publish();
`ifdef OLED_DOUBLE_BUFFER_EN
        fb_swap_req = 1'b1;
        @(posedge clk); #1;
        fb_swap_req = 1'b0;
        step("pub543", 543);
        check("pub_ack_early", 16'(ack_cnt), 16'd0);
        front_idx = front_idx ^ 1;
        step("pub26", 26);
        check("pub_frame_done", 16'(fd_cnt), 16'd1);
        check("pub_swap_ack", 16'(ack_cnt), 16'd1);
`endif
    endtask

    initial begin
        rst              = 1'b1;
        fb_we            = 1'b0;
        fb_waddr         = '0;
        fb_wdata         = '0;
        bus.data_counter = '0;
`ifdef OLED_DOUBLE_BUFFER_EN
        fb_swap_req      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        fill(8'h5A);
`ifdef OLED_DOUBLE_BUFFER_EN
        publish();
        fill(8'h5A);
`endif
        // reset state (fresh reset; framebuffer is kept)
        rst              = 1'b1;
        bus.data_counter = '0;
        repeat (2) begin @(posedge clk); #1; end
        front_idx = 0;
        check("rst.ctrl", 16'(bus.control_byte_out), 16'h00);
        check("rst.data", 16'(bus.data_byte_out), 16'hAE);
        check("rst.cont", 16'(bus.continue_bit), 16'd0);
        check("rst.init_done", 16'(init_done), 16'd0);
        check("rst.frame_done", 16'(frame_done), 16'd0);
        check("rst.addr", 16'(bus.addr_byte_out), 16'h3C);
        check("rst.rw", 16'(bus.read_write), 16'd0);

        // release with counter 0: exactly 2 clks to a valid lookup
        rst = 1'b0;
        sb_q.push_back(exp_of(0));
        await_check("rel", 2);

        step("init25", 25);
        step("init3", 3);
        check("init_done_low", 16'(init_done), 16'd0);
        step("enter26", 26);
        check("init_done_set", 16'(init_done), 16'd1);
        check("enter_no_fd", 16'(fd_cnt), 16'd0);

        fb_write(5, 8'h3C);
        publish();
        step("fb5", 31);
        step("pad540", 540);

        step("pre_wrap", 543);
        step("wrap", 26);
        check("wrap_frame_done", 16'(fd_cnt), 16'd1);
        step("jump100", 100);
        step("jump30", 30);
        check("jump_no_fd", 16'(fd_cnt), 16'd0);

        step("hold600", 600);
        step("hold_exit27", 27);

        // write and read address 7 in the same clk: old data comes out
        sb_q.push_back(exp_of(33));
        bus.data_counter = 10'd33;
        fb_we    = 1'b1;
        fb_waddr = 9'd7;
        fb_wdata = 8'hFF;
        @(posedge clk); #1;
        fb_we = 1'b0;
        model_wr(7, 8'hFF);
        await_check("collide_old", 2);
        step("away34", 34);
        publish();
        step("collide_new", 33);

        fb_write(511, 8'hC3);
        publish();
        step("last537", 537);
        step("addr7_kept", 33);

        // reset mid-stream: one clk to reset values, framebuffer survives
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst.ctrl", 16'(bus.control_byte_out), 16'h00);
        check("mid_rst.data", 16'(bus.data_byte_out), 16'hAE);
        check("mid_rst.cont", 16'(bus.continue_bit), 16'd0);
        check("mid_rst.init_done", 16'(init_done), 16'd0);
        rst = 1'b0;
        front_idx = 0;
        sb_q.push_back(exp_of(33));
        await_check("post_rst", 2);
        step("post_rst_fb5", 31);

        check("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
